// File: rtl/seed_stim_pkg.sv
// Shared types, defaults and the xorshift64 step for the seeded stimulus
// generator.
package seed_stim_pkg;

    localparam logic [63:0] DEFAULT_SEED = 64'h9581_C6F0_3A1D_4E27;
    localparam int MAX_BURST = 16;

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        DONE
    } state_t;

    typedef struct packed {
        logic [4:0][15:0] u;
        logic [3:0][2:0]  pkja;
        logic             gk;
    } beat_t;

    function automatic logic [63:0] xs64_step(input logic [63:0] x);
        logic [63:0] v;
        v = x;
        v = v ^ (v << 13);
        v = v ^ (v >> 7);
        v = v ^ (v << 17);
        return v;
    endfunction

    function automatic beat_t map_beat(
        input logic [63:0] a,
        input logic [63:0] b
    );
        beat_t r;
        r.u[0] = a[15:0];
        r.u[1] = a[31:16];
        r.u[2] = a[47:32];
        r.u[3] = a[63:48];
        r.u[4] = b[15:0];
        r.pkja = b[27:16];
        r.gk   = b[28];
        return r;
    endfunction

endpackage

// File: rtl/seed_stim_if.sv
// Beat stream from the generator to its consumer: valid/ready plus the
// five signed lanes, the packed word and the control flag.
interface seed_stim_if;

    logic             out_valid;
    logic             out_ready;
    shortint          out_u [4:0];
    bit   [3:0][3:1]  out_pkja;
    logic             out_gk;

    modport master (
        output out_valid,
        output out_u,
        output out_pkja,
        output out_gk,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_u,
        input  out_pkja,
        input  out_gk,
        output out_ready
    );

endinterface

// File: rtl/seed_stim_ctrl.sv
// Burst FSM and remaining-beat counter; tells the datapath when to
// register a fresh beat.
module seed_stim_ctrl #(
    parameter int MAX_BURST = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [4:0] burst_len,
    input  logic       accept,
    output logic       idle,
    output logic       step,
    output logic       busy,
    output logic       done,
    output logic       valid
);
    import seed_stim_pkg::*;

    localparam logic [4:0] MAX_LEN = 5'(MAX_BURST);

    state_t     state;
    state_t     state_next;
    logic [4:0] cnt;
    logic [4:0] cnt_next;
    logic [4:0] eff_len;

    assign eff_len = (burst_len == 5'd0 || burst_len > MAX_LEN)
                   ? MAX_LEN : burst_len;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 5'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        idle       = 1'b0;
        step       = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        valid      = 1'b0;
        unique case (state)
            IDLE: begin
                idle = 1'b1;
                if (start) begin
                    step       = 1'b1;
                    cnt_next   = eff_len;
                    state_next = ACTIVE;
                end
            end
            ACTIVE: begin
                busy  = 1'b1;
                valid = 1'b1;
                if (accept) begin
                    // Count saturates at zero on the final beat
                    if (cnt <= 5'd1) begin
                        cnt_next   = 5'd0;
                        state_next = DONE;
                    end else begin
                        cnt_next = cnt - 5'd1;
                        step     = 1'b1;
                    end
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: rtl/seed_stim_gen.sv
// Seeded xorshift64 stimulus generator: two chained PRNG steps per beat,
// streamed over a valid/ready interface in bursts.
module seed_stim_gen #(
    parameter logic [63:0] DEFAULT_SEED = seed_stim_pkg::DEFAULT_SEED,
    parameter int          MAX_BURST    = seed_stim_pkg::MAX_BURST
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        seed_load,
    input  logic [63:0] seed_val,
    input  logic        start,
    input  logic [4:0]  burst_len,
    seed_stim_if.master stim,
    output logic        busy,
    output logic        done,
    output logic [63:0] seed_now
);
    import seed_stim_pkg::*;

    logic [63:0] s_q;
    logic [63:0] s_base;
    logic [63:0] a;
    logic [63:0] b;
    beat_t       beat_q;
    logic        idle;
    logic        step;
    logic        valid;
    logic        accept;

    assign accept = valid & stim.out_ready;

    seed_stim_ctrl #(
        .MAX_BURST (MAX_BURST)
    ) u_ctrl (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .burst_len (burst_len),
        .accept    (accept),
        .idle      (idle),
        .step      (step),
        .busy      (busy),
        .done      (done),
        .valid     (valid)
    );

    // A seed loaded alongside start feeds the first beat directly
    assign s_base = (idle && seed_load)
                  ? ((seed_val == 64'd0) ? DEFAULT_SEED : seed_val)
                  : s_q;

    assign a = xs64_step(s_base);
    assign b = xs64_step(a);

    always_ff @(posedge clk) begin
        if (rst) begin
            s_q    <= DEFAULT_SEED;
            beat_q <= '0;
        end else if (step) begin
            s_q    <= b;
            beat_q <= map_beat(a, b);
        end else begin
            s_q    <= s_base;
        end
    end

    always_comb begin
        for (int i = 0; i < 5; i++) begin
            stim.out_u[i] = shortint'(beat_q.u[i]);
        end
    end

    assign stim.out_valid = valid;
    assign stim.out_pkja  = beat_q.pkja;
    assign stim.out_gk    = beat_q.gk;
    assign seed_now       = s_q;

endmodule

// File: doc/seed_stim_gen.md
SEED_STIM_GEN -- requirements
Module: seed_stim_gen

Interface
REQ-001 SHALL have parameter DEFAULT_SEED, default 64'h9581_C6F0_3A1D_4E27, meaning the PRNG state after reset, and the substitute for any zero seed.
REQ-002 SHALL have parameter MAX_BURST, default 16, meaning the maximum number of beats per burst.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 seed_load  input  1  loads seed_val, honoured only in IDLE.
REQ-007 seed_val  input  64  new PRNG seed.
REQ-008 start  input  1  begins a burst, honoured only in IDLE.
REQ-009 burst_len  input  5  beats per burst, sampled on start; 0 or any value above MAX_BURST means MAX_BURST.
REQ-010 out_valid  output  1  beat available.
REQ-011 out_ready  input  1  consumer accepts the beat.
REQ-012 out_u  output  shortint [4:0] unpacked  five signed lanes.
REQ-013 out_pkja  output  bit [3:0][3:1]  12-bit packed word.
REQ-014 out_gk  output  1  single-bit control flag for the consumer.
REQ-015 busy  output  1  high in ACTIVE.
REQ-016 done  output  1  one-cycle pulse after the last beat is accepted.
REQ-017 seed_now  output  64  current PRNG state.

Function
REQ-018 The PRNG step SHALL be xorshift64: x^=x<<13; x^=x>>7; x^=x<<17, on 64-bit unsigned values.
REQ-019 Each beat SHALL use two chained steps a=step(S) and b=step(a), computed in a single cycle, with next S=b.
REQ-020 Beat mapping SHALL be: out_u[0..3]=a[15:0],a[31:16],a[47:32],a[63:48]; out_u[4]=b[15:0]; out_pkja=b[27:16] (out_pkja[3]=b[27:25] ... out_pkja[0]=b[18:16]); out_gk=b[28].
REQ-021 The FSM SHALL have states IDLE, ACTIVE and DONE, with transitions IDLE->ACTIVE on start, ACTIVE->DONE on acceptance of the final beat, and DONE->IDLE unconditionally after one cycle.
REQ-022 Start SHALL give a latency of one cycle: out_valid is high and the first beat is registered in the cycle after start.
REQ-023 Handshake: a beat SHALL transfer when out_valid&&out_ready; while out_valid=1 and out_ready=0, all out_* SHALL hold stable.
REQ-024 On a non-final acceptance, the next beat SHALL be registered in the same edge, so out_valid stays high and back-to-back transfer runs at one beat per cycle.
REQ-025 On acceptance of the final beat, out_valid SHALL deassert the next cycle and done=1 for exactly that cycle.
REQ-026 If seed_load and start are asserted in the same IDLE cycle, the seed SHALL load first and the first beat SHALL derive from the new seed.
REQ-027 A seed_val of 0 SHALL load DEFAULT_SEED.
REQ-028 seed_load and start asserted while in ACTIVE or DONE SHALL be ignored, with no queuing.
REQ-029 The beat counter SHALL be 5 bits; the burst ends when the remaining count reaches 0, with no wrap.
REQ-030 seed_now SHALL equal S at all times, so that after a burst of N beats it reflects 2N steps.

Reset
REQ-031 On rst, the block SHALL enter IDLE with S=DEFAULT_SEED; out_valid, busy and done =0; out_u, out_pkja and out_gk =0; the counter =0.
REQ-032 rst during ACTIVE SHALL abort the burst immediately, with no done pulse and the in-flight beat discarded.
REQ-033 rst SHALL dominate seed_load and start asserted in the same cycle.

Structure
REQ-034 Package seed_stim_pkg SHALL hold DEFAULT_SEED, MAX_BURST, the FSM state enum, and a beat_t struct of u, pkja and gk.
REQ-035 The xorshift64 step SHALL be a pure function in seed_stim_pkg, with no sub-module.
REQ-036 One sub-module SHALL exist, seed_stim_ctrl, containing the FSM and beat counter; the datapath SHALL remain in seed_stim_gen.

Verification
REQ-037 Scenario: seed_load=1 with seed_val=1, then start with burst_len=1 -> next cycle out_u[0]=16'h2041, out_u[1]=16'h4082, out_u[2]=0, out_u[3]=0, out_valid=1.
REQ-038 Scenario: burst_len=3 with out_ready held 1 -> out_valid high for 3 consecutive cycles, done pulses once on the 4th cycle, and seed_now equals 6 reference steps from the start seed.
REQ-039 Scenario: out_ready=0 for 5 cycles mid-burst -> all outputs stay bit-stable, and no beat is lost or duplicated against the reference model.
REQ-040 Scenario: seed_load with seed_val=0 -> seed_now=DEFAULT_SEED; start applied while busy -> ignored, and the burst length is unchanged.
REQ-041 Scenario: rst on the 2nd beat of a 4-beat burst -> the next cycle shows out_valid=0, done=0, busy=0, seed_now=DEFAULT_SEED.
REQ-042 Scenario: burst_len=0 and burst_len=20 -> exactly 16 beats each.
